// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store front-end: access sizes,
// FSM states and the alignment rule used by the error decode.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

  // A halfword must sit on an even byte, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Lane steering for little-endian sub-word access: extracts and extends load
// lanes, and splices store data into a previously read word.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_r_data,
  input  logic [31:0] i_merge_q,
  input  logic [31:0] i_w_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  assign w_byte = i_r_data[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_r_data[31:16] : i_r_data[15:0];

  always_comb begin
    o_load_data = 32'h0;
    w_sign      = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_sign      = ~i_unsigned & w_byte[7];
        o_load_data = {{24{w_sign}}, w_byte};
      end
      SZ_HALF: begin
        w_sign      = ~i_unsigned & w_half[15];
        o_load_data = {{16{w_sign}}, w_half};
      end
      SZ_WORD: o_load_data = i_r_data;
      default: o_load_data = 32'h0;
    endcase
  end

  // Only the addressed lane(s) change; the rest of the old word passes through.
  always_comb begin
    o_merge_data = i_merge_q;
    case (i_size)
      SZ_BYTE: o_merge_data[{i_addr_lo, 3'b000} +: 8] = i_w_data[7:0];
      SZ_HALF: begin
        if (i_addr_lo[1]) o_merge_data[31:16] = i_w_data[15:0];
        else              o_merge_data[15:0]  = i_w_data[15:0];
      end
      default: o_merge_data = i_merge_q;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: error decode, single-cycle loads and word
// stores, and a two-cycle read-modify-write for byte/halfword stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_addr_err,
  output logic        o_err_sticky,
  output logic        o_mem_w_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_w_data,
  input  logic [31:0] i_mem_r_data
);

  localparam logic [29:0] LP_WORD_LIMIT = 30'(MEM_WORDS);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_merge_q;
  logic        r_err_sticky;
  logic        w_addr_err;
  logic        w_capture;
  logic [31:0] w_load_aligned;
  logic [31:0] w_merge_data;

  assign o_mem_addr = {2'b00, i_req_addr[31:2]};

  assign w_addr_err = i_req_valid &
                      ((i_req_size == SZ_ILLEGAL) ||
                       is_misaligned(i_req_size, i_req_addr[1:0]) ||
                       (i_req_addr[31:2] >= LP_WORD_LIMIT));
  assign o_addr_err   = w_addr_err;
  assign o_err_sticky = r_err_sticky;

  mem_lane_align u_lane_align (
    .i_addr_lo    (i_req_addr[1:0]),
    .i_size       (i_req_size),
    .i_unsigned   (i_req_unsigned),
    .i_r_data     (i_mem_r_data),
    .i_merge_q    (r_merge_q),
    .i_w_data     (i_req_wdata),
    .o_load_data  (w_load_aligned),
    .o_merge_data (w_merge_data)
  );

  // Faulting or idle requests return zero so no stale lane leaks downstream.
  assign o_load_data = (i_req_valid && !w_addr_err) ? w_load_aligned : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_merge_q    <= 32'h0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_err_sticky <= r_err_sticky | w_addr_err;
      if (w_capture) r_merge_q <= i_mem_r_data;
    end
  end

  // The request is held by upstream during RMW, so it is not re-qualified there.
  always_comb begin
    w_next_state = r_state;
    o_stall      = 1'b0;
    o_mem_w_en   = 1'b0;
    o_mem_w_data = i_req_wdata;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid && !w_addr_err && i_req_we) begin
          if (i_req_size == SZ_WORD) begin
            o_mem_w_en = 1'b1;
          end else begin
            o_stall      = 1'b1;
            w_capture    = 1'b1;
            w_next_state = ST_RMW;
          end
        end
      end
      ST_RMW: begin
        o_mem_w_en   = 1'b1;
        o_mem_w_data = w_merge_data;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// RMW/reset sequences and a randomized run against a word-level memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        stall;
  logic [31:0] loadData;
  logic        addrErr;
  logic        errSticky;
  logic        memWEn;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;

  logic [31:0] mem [0:99];
  logic [31:0] refMem [0:99];
  logic        preloadEn = 1'b0;
  logic [6:0]  preloadIdx = 7'd0;
  logic [31:0] preloadVal = 32'h0;
  int          writeCount = 0;

  int checkCount = 0;
  int failCount  = 0;
  logic stickyExp;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic        expWen;
    logic        checkLoad;
    logic [31:0] expLoad;
  } vec_t;

  vec_t vecs [14];

  mem_access_unit #(.MEM_WORDS(100)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (reqValid),
    .i_req_we       (reqWe),
    .i_req_size     (reqSize),
    .i_req_unsigned (reqUnsigned),
    .i_req_addr     (reqAddr),
    .i_req_wdata    (reqWdata),
    .o_stall        (stall),
    .o_load_data    (loadData),
    .o_addr_err     (addrErr),
    .o_err_sticky   (errSticky),
    .o_mem_w_en     (memWEn),
    .o_mem_addr     (memAddr),
    .o_mem_w_data   (memWData),
    .i_mem_r_data   (memRData)
  );

  always #5 clk = ~clk;

  // Word-addressed data memory: combinational read, write on the rising edge.
  assign memRData = (memAddr < 32'd100) ? mem[memAddr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (preloadEn) begin
      mem[preloadIdx] <= preloadVal;
    end else if (memWEn && memAddr < 32'd100) begin
      mem[memAddr[6:0]] <= memWData;
      writeCount <= writeCount + 1;
    end
  end

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input int lo);
    logic [31:0] v;
    case (size)
      2'b00: begin
        v = (word >> (8 * lo)) & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      2'b01: begin
        v = (word >> (8 * lo)) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] modelMerge(input logic [31:0] old, input logic [1:0] size,
                                             input int lo, input logic [31:0] wdata);
    logic [31:0] mask;
    mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * lo);
    return (old & ~mask) | ((wdata << (8 * lo)) & mask);
  endfunction

  function automatic logic modelErr(input logic [1:0] size, input logic [31:0] addr);
    int lo;
    lo = int'(addr % 4);
    return (addr / 4 >= 100) || (size == 2'b11) ||
           (size == 2'b01 && (lo % 2) != 0) || (size == 2'b10 && lo != 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    reqValid    = valid;
    reqWe       = we;
    reqSize     = size;
    reqUnsigned = uns;
    reqAddr     = addr;
    reqWdata    = wdata;
  endtask

  task automatic preloadWord(input int idx, input logic [31:0] val);
    @(posedge clk);
    #1;
    preloadEn  = 1'b1;
    preloadIdx = 7'(idx);
    preloadVal = val;
    refMem[idx] = val;
    @(posedge clk);
    #1;
    preloadEn = 1'b0;
  endtask

  // One request driven through the memory model: single-cycle or two-cycle RMW.
  task automatic runModelOp(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic        expErr;
    int          idx;
    int          lo;
    logic [31:0] merged;
    expErr = modelErr(size, addr);
    idx    = int'(addr / 4);
    lo     = int'(addr % 4);
    applyStimulus(1'b1, we, size, uns, addr, wdata);
    @(negedge clk);
    checkOutput("rnd_sticky", {31'h0, errSticky}, {31'h0, stickyExp});
    checkOutput("rnd_err", {31'h0, addrErr}, {31'h0, expErr});
    checkOutput("rnd_addr", memAddr, addr / 4);
    stickyExp = stickyExp | expErr;
    if (expErr) begin
      checkOutput("rnd_err_wen", {31'h0, memWEn}, 32'h0);
      checkOutput("rnd_err_stall", {31'h0, stall}, 32'h0);
      checkOutput("rnd_err_load", loadData, 32'h0);
    end else if (!we) begin
      checkOutput("rnd_load", loadData, modelLoad(refMem[idx], size, uns, lo));
      checkOutput("rnd_load_wen", {31'h0, memWEn}, 32'h0);
    end else if (size == 2'b10) begin
      checkOutput("rnd_sw_wen", {31'h0, memWEn}, 32'h1);
      checkOutput("rnd_sw_data", memWData, wdata);
      checkOutput("rnd_sw_stall", {31'h0, stall}, 32'h0);
      refMem[idx] = wdata;
    end else begin
      checkOutput("rnd_rmw1_stall", {31'h0, stall}, 32'h1);
      checkOutput("rnd_rmw1_wen", {31'h0, memWEn}, 32'h0);
      merged = modelMerge(refMem[idx], size, lo, wdata);
      @(negedge clk);
      checkOutput("rnd_rmw2_wen", {31'h0, memWEn}, 32'h1);
      checkOutput("rnd_rmw2_stall", {31'h0, stall}, 32'h0);
      checkOutput("rnd_rmw2_data", memWData, merged);
      refMem[idx] = merged;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h5,   32'h0,        1'b0, 1'b0, 1'b1, 32'hFFFFFFAA};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h5,   32'h0,        1'b0, 1'b0, 1'b1, 32'h000000AA};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h6,   32'h0,        1'b0, 1'b0, 1'b1, 32'hFFFF8899};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h6,   32'h0,        1'b0, 1'b0, 1'b1, 32'h00008899};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        1'b0, 1'b0, 1'b1, 32'h8899AABB};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h7,   32'h0,        1'b0, 1'b0, 1'b1, 32'h00000088};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h4,   32'h0,        1'b0, 1'b0, 1'b1, 32'h0000AABB};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h8,   32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h3,   32'h1234,     1'b1, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h2,   32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'd400, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 32'd400, 32'h5555AAAA, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 32'h0};

    reset = 1'b0;
    reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = 32'h0; reqWdata = 32'h0;
    stickyExp = 1'b0;

    for (int i = 0; i < 100; i++) preloadWord(i, $urandom);
    preloadWord(1, 32'h8899AABB);
    preloadWord(2, 32'h11223344);

    @(negedge clk);
    checkOutput("reset_stall", {31'h0, stall}, 32'h0);
    checkOutput("reset_wen", {31'h0, memWEn}, 32'h0);
    checkOutput("reset_sticky", {31'h0, errSticky}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle request still drives the word index.
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    checkOutput("idle_addr", memAddr, 32'd9);
    checkOutput("idle_err", {31'h0, addrErr}, 32'h0);
    checkOutput("idle_wen", {31'h0, memWEn}, 32'h0);

    // sb 0xEE @0x9 into mem[2]=0x11223344.
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h9, 32'h000000EE);
    @(negedge clk);
    checkOutput("sb_c1_stall", {31'h0, stall}, 32'h1);
    checkOutput("sb_c1_wen", {31'h0, memWEn}, 32'h0);
    @(negedge clk);
    checkOutput("sb_c2_stall", {31'h0, stall}, 32'h0);
    checkOutput("sb_c2_wen", {31'h0, memWEn}, 32'h1);
    checkOutput("sb_c2_data", memWData, 32'h1122EE44);
    refMem[2] = 32'h1122EE44;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    checkOutput("sb_readback", loadData, 32'h1122EE44);
    checkOutput("sb_sticky", {31'h0, errSticky}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_err", i), {31'h0, addrErr}, {31'h0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d_wen", i), {31'h0, memWEn}, {31'h0, vecs[i].expWen});
      checkOutput($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
      checkOutput($sformatf("vec%0d_addr", i), memAddr, vecs[i].addr >> 2);
      if (vecs[i].checkLoad) checkOutput($sformatf("vec%0d_load", i), loadData, vecs[i].expLoad);
      if (vecs[i].expWen) begin
        checkOutput($sformatf("vec%0d_wdata", i), memWData, vecs[i].wdata);
        refMem[vecs[i].addr >> 2] = vecs[i].wdata;
      end
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("sticky_set", {31'h0, errSticky}, 32'h1);

    // sh 0xBEEF @0x4 aborted by reset during the RMW cycle.
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h4, 32'h0000BEEF);
    @(negedge clk);
    checkOutput("abort_c1_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    reqValid = 1'b0;
    begin
      int writesBefore;
      writesBefore = writeCount;
      @(negedge clk);
      checkOutput("abort_wen", {31'h0, memWEn}, 32'h0);
      checkOutput("abort_stall", {31'h0, stall}, 32'h0);
      checkOutput("abort_sticky", {31'h0, errSticky}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      @(negedge clk);
      checkOutput("abort_no_commit", 32'(writeCount), 32'(writesBefore));
      checkOutput("abort_mem_unchanged", loadData, 32'h8899AABB);
      checkOutput("abort_idle_wen", {31'h0, memWEn}, 32'h0);
    end

    stickyExp = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] addr;
      addr = ($urandom_range(0, 109) << 2) | ($urandom & 32'h3);
      runModelOp(1'(($urandom) % 2), 2'($urandom_range(0, 3)), 1'(($urandom) % 2), addr, $urandom);
    end

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      @(negedge clk);
      checkOutput($sformatf("sweep%0d", i), loadData, refMem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
